// File: rtl/conv_pool_engine_pkg.sv
// rtl/conv_pool_engine_pkg.sv - shared state encoding, tap offsets and bank mapping for conv_pool_engine
package conv_pool_engine_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_CONV, S_CWR, S_POOL, S_PWR, S_FLAT, S_FWR, S_DONE
  } state_e;

  localparam int DATA_W_DEF = 20;
  localparam int ACC_W      = 2 * DATA_W_DEF + 4;

  function automatic int acc_width(input int data_w);
    return 2 * data_w + 4;
  endfunction

  // Row offset of 3x3 tap t (row-major, t = 0..8); anything else maps to 0
  function automatic logic signed [1:0] tap_dy(input logic [3:0] t);
    if (t < 4'd3)      return -2'sd1;
    else if (t < 4'd6) return 2'sd0;
    else if (t < 4'd9) return 2'sd1;
    else               return 2'sd0;
  endfunction

  function automatic logic signed [1:0] tap_dx(input logic [3:0] t);
    case (t)
      4'd0, 4'd3, 4'd6: return -2'sd1;
      4'd2, 4'd5, 4'd8: return 2'sd1;
      default:          return 2'sd0;
    endcase
  endfunction

  // Layer-memory bank for each phase: conv k, pool k, flatten, idle 0
  function automatic int bank_sel(input state_e s, input int k, input int n_ker);
    case (s)
      S_CONV, S_CWR, S_POOL: return 1 + k;
      S_PWR, S_FLAT:         return 1 + n_ker + k;
      S_FWR:                 return 1 + 2 * n_ker;
      default:               return 0;
    endcase
  endfunction

endpackage

// File: rtl/conv_pool_engine_mac.sv
// rtl/conv_pool_engine_mac.sv - multiply-accumulate with bias add, round-half-up, saturation and ReLU
module conv_mac
  import conv_pool_engine_pkg::*;
#(
  parameter int DATA_W = 20,
  parameter int FRAC   = 16,
  parameter int ACC_W  = 44
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     clr_i,
  input  logic                     mac_en_i,
  input  logic                     bias_en_i,
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  output logic        [DATA_W-1:0] res_o
);

  localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1) << (FRAC - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX  =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc_q, acc_d, bias_ext, rnd, shifted;

  assign prod     = a_i * b_i;
  assign bias_ext = {{(ACC_W-DATA_W){b_i[DATA_W-1]}}, b_i} <<< FRAC;

  always_comb begin
    acc_d = acc_q;
    if (clr_i)          acc_d = '0;
    else if (mac_en_i)  acc_d = acc_q + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    else if (bias_en_i) acc_d = acc_q + bias_ext;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) acc_q <= '0;
    else         acc_q <= acc_d;
  end

  // Saturating to the signed range and then clamping negatives is the same as clamping to [0, max]
  always_comb begin
    rnd     = acc_q + RND_HALF;
    shifted = rnd >>> FRAC;
    if (shifted < 0)             res_o = '0;
    else if (shifted > SAT_MAX)  res_o = SAT_MAX[DATA_W-1:0];
    else                         res_o = shifted[DATA_W-1:0];
  end

endmodule

// File: rtl/conv_pool_engine.sv
// rtl/conv_pool_engine.sv - 3x3 conv + bias + ReLU, optional 2x2 max-pool and channel-interleaved flatten
module conv_pool_engine
  import conv_pool_engine_pkg::*;
#(
  parameter int IMG_LOG2 = 6,
  parameter int DATA_W   = 20,
  parameter int FRAC     = 16,
  parameter int N_KER    = 2,
  parameter int CSEL_W   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ready,
  input  logic                  pool_en,
  output logic                  busy,
  output logic                  done,
  output logic [2*IMG_LOG2-1:0] iaddr,
  input  logic [DATA_W-1:0]     idata,
  output logic [7:0]            waddr,
  input  logic [DATA_W-1:0]     wdata,
  output logic                  crd,
  output logic                  cwr,
  output logic [2*IMG_LOG2-1:0] caddr_rd,
  input  logic [DATA_W-1:0]     cdata_rd,
  output logic [2*IMG_LOG2-1:0] caddr_wr,
  output logic [DATA_W-1:0]     cdata_wr,
  output logic [CSEL_W-1:0]     csel
);

  localparam int AW    = 2 * IMG_LOG2;
  localparam int MAC_W = acc_width(DATA_W);
  localparam logic [IMG_LOG2-1:0] FULL_LAST = '1;
  localparam logic [IMG_LOG2-1:0] HALF_LAST = {1'b0, {(IMG_LOG2-1){1'b1}}};
  localparam logic [CSEL_W-1:0]   K_LAST    = CSEL_W'(N_KER - 1);

  state_e              state_q;
  logic [CSEL_W-1:0]   k_q;
  logic [IMG_LOG2-1:0] y_q, x_q;
  logic [3:0]          c_q;
  logic                pool_q, tap_ok_q;
  logic [DATA_W-1:0]   max_q, cdata_wr_q;
  logic [AW-1:0]       caddr_wr_q;

  logic signed [1:0]   dy, dx;
  logic [IMG_LOG2:0]   ty, tx;
  logic                in_img;
  logic [IMG_LOG2-1:0] lim, x_d, y_d;
  logic [CSEL_W-1:0]   k_d;
  logic                phase_end;
  logic [DATA_W-1:0]   max_d, mac_res;
  logic [AW-1:0]       flat_addr;
  logic                mac_clr, mac_en, bias_en;

  // Tap coordinates carry one extra bit so both -1 and SIDE show up as bit IMG_LOG2 set
  always_comb begin
    dy     = tap_dy(c_q);
    dx     = tap_dx(c_q);
    ty     = {1'b0, y_q} + {{(IMG_LOG2-1){dy[1]}}, dy};
    tx     = {1'b0, x_q} + {{(IMG_LOG2-1){dx[1]}}, dx};
    in_img = ~ty[IMG_LOG2] & ~tx[IMG_LOG2];
  end

  // Shared k/y/x raster advance; pool and flatten walk the half-size pooled grid
  always_comb begin
    lim       = (state_q == S_CWR) ? FULL_LAST : HALF_LAST;
    x_d       = (x_q == lim) ? '0 : x_q + IMG_LOG2'(1);
    y_d       = (x_q == lim) ? ((y_q == lim) ? '0 : y_q + IMG_LOG2'(1)) : y_q;
    phase_end = (x_q == lim) && (y_q == lim) && (k_q == K_LAST);
    k_d       = ((x_q == lim) && (y_q == lim)) ? (phase_end ? '0 : k_q + CSEL_W'(1)) : k_q;
  end

  always_comb begin
    max_d = max_q;
    if (c_q == 4'd1 || $signed(cdata_rd) > $signed(max_q)) max_d = cdata_rd;
    flat_addr = AW'({y_q[IMG_LOG2-2:0], x_q[IMG_LOG2-2:0]}) * AW'(N_KER) + AW'(k_q);
  end

  assign mac_clr = (state_q == S_CONV) && (c_q == 4'd0);
  assign mac_en  = (state_q == S_CONV) && (c_q >= 4'd1) && (c_q <= 4'd9) && tap_ok_q;
  assign bias_en = (state_q == S_CONV) && (c_q == 4'd10);

  conv_mac #(
    .DATA_W (DATA_W),
    .FRAC   (FRAC),
    .ACC_W  (MAC_W)
  ) u_mac (
    .clk_i     (clk),
    .reset_i   (reset),
    .clr_i     (mac_clr),
    .mac_en_i  (mac_en),
    .bias_en_i (bias_en),
    .a_i       (idata),
    .b_i       (wdata),
    .res_o     (mac_res)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      y_q        <= '0;
      x_q        <= '0;
      c_q        <= '0;
      pool_q     <= 1'b0;
      tap_ok_q   <= 1'b0;
      max_q      <= '0;
      caddr_wr_q <= '0;
      cdata_wr_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (ready) begin
          pool_q  <= pool_en;
          k_q     <= '0;
          y_q     <= '0;
          x_q     <= '0;
          c_q     <= '0;
          state_q <= S_CONV;
        end
        S_CONV: begin
          tap_ok_q <= in_img;
          if (c_q == 4'd11) begin
            cdata_wr_q <= mac_res;
            caddr_wr_q <= {y_q, x_q};
            c_q        <= '0;
            state_q    <= S_CWR;
          end else begin
            c_q <= c_q + 4'd1;
          end
        end
        S_CWR: begin
          x_q     <= x_d;
          y_q     <= y_d;
          k_q     <= k_d;
          state_q <= phase_end ? (pool_q ? S_POOL : S_DONE) : S_CONV;
        end
        S_POOL: begin
          if (c_q != 4'd0) max_q <= max_d;
          if (c_q == 4'd4) begin
            cdata_wr_q <= max_d;
            caddr_wr_q <= {y_q, x_q};
            c_q        <= '0;
            state_q    <= S_PWR;
          end else begin
            c_q <= c_q + 4'd1;
          end
        end
        S_PWR: begin
          x_q     <= x_d;
          y_q     <= y_d;
          k_q     <= k_d;
          state_q <= phase_end ? S_FLAT : S_POOL;
        end
        S_FLAT: begin
          if (c_q == 4'd1) begin
            cdata_wr_q <= cdata_rd;
            caddr_wr_q <= flat_addr;
            c_q        <= '0;
            state_q    <= S_FWR;
          end else begin
            c_q <= c_q + 4'd1;
          end
        end
        S_FWR: begin
          x_q     <= x_d;
          y_q     <= y_d;
          k_q     <= k_d;
          state_q <= phase_end ? S_DONE : S_FLAT;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Strobes and read addresses decode directly from the state/counter registers
  always_comb begin
    busy     = (state_q != S_IDLE) && (state_q != S_DONE);
    done     = (state_q == S_DONE);
    iaddr    = '0;
    waddr    = '0;
    crd      = 1'b0;
    caddr_rd = '0;
    cwr      = (state_q == S_CWR) || (state_q == S_PWR) || (state_q == S_FWR);
    csel     = CSEL_W'(bank_sel(state_q, int'(k_q), N_KER));
    caddr_wr = caddr_wr_q;
    cdata_wr = cdata_wr_q;
    if (state_q == S_CONV) begin
      iaddr = {ty[IMG_LOG2-1:0], tx[IMG_LOG2-1:0]};
      if (c_q <= 4'd9) waddr = 8'(k_q) * 8'd10 + 8'(c_q);
    end
    if (state_q == S_POOL) begin
      crd      = (c_q < 4'd4);
      caddr_rd = {y_q[IMG_LOG2-2:0], c_q[1], x_q[IMG_LOG2-2:0], c_q[0]};
    end
    if (state_q == S_FLAT) begin
      crd      = (c_q == 4'd0);
      caddr_rd = {y_q, x_q};
    end
  end

endmodule
